hdmi_oser_lane_ctrl: RTL



---
 rtl/hdmi_oser_pkg.sv | 30 +++
 rtl/hdmi_oser_lane_ctrl_lock_filter.sv | 45 ++++
 rtl/hdmi_oser_lane_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hdmi_oser_pkg.sv
// Shared definitions for the HDMI serializer lane controller: FSM state
// encoding, TMDS control/clock symbols and the lock-loss counter width.
package hdmi_oser_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RST_HOLD  = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } lane_state_t;

    // TMDS control symbol for C1C0 = 00, used whenever real data is not flowing.
    localparam logic [9:0] IDLE_WORD = 10'b1101010100;
    // Five ones then five zeros: one pixel-clock period on the clock lane.
    localparam logic [9:0] CLK_WORD  = 10'b1111100000;

    localparam int LOSS_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        logic [LOSS_CNT_W-1:0] r;
        if (v == {LOSS_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(LOSS_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/hdmi_oser_lane_ctrl_lock_filter.sv
// PLL lock qualifier: two-flop synchronizer followed by a counter of
// consecutive high samples. lock_stable is asserted in the cycle where the
// counter is about to reach LOCK_FILTER, so the consumer changes state on
// the same edge the count is reached; the counter then restarts from zero.
import hdmi_oser_pkg::*;

module hdmi_oser_lane_ctrl_lock_filter #(
    parameter int LOCK_FILTER = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    output logic lock_s,
    output logic lock_stable
);

    localparam int CW = $clog2(LOCK_FILTER + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;

    assign lock_s      = sync2_r;
    assign lock_stable = sync2_r && (cnt_r == CW'(LOCK_FILTER - 1));

    // Synchronize pll_lock and count consecutive synchronized-high cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= pll_lock;
            sync2_r <= sync1_r;
            if (!sync2_r) begin
                cnt_r <= '0;
            end else if (lock_stable) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hdmi_oser_lane_ctrl.sv
// Bring-up / run-time controller for three TMDS data-lane serializers and
// the TMDS clock lane. Sequence: wait for a filtered PLL lock, hold the
// serializers in reset, flush idle symbols, then pass encoder words.
// Any loss of synchronized lock after WAIT_LOCK tears the link down.
// Optional feature macro: HDMI_OSER_TEST_PATTERN_EN adds test_mode, which
// replaces the data lanes with CLK_WORD while in RUN.
import hdmi_oser_pkg::*;

module hdmi_oser_lane_ctrl #(
    parameter int LOCK_FILTER    = 64,
    parameter int SER_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 8
) (
    input  logic                  paralell_clk,
    input  logic                  reset,
    input  logic                  pll_lock,
`ifdef HDMI_OSER_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic                  tmds_valid,
    input  logic [9:0]            tmds_in_0,
    input  logic [9:0]            tmds_in_1,
    input  logic [9:0]            tmds_in_2,
    output logic                  ser_reset,
    output logic [9:0]            paralell_data_0,
    output logic [9:0]            paralell_data_1,
    output logic [9:0]            paralell_data_2,
    output logic [9:0]            paralell_data_clk,
    output logic                  link_ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int TMAX = (SER_RST_CYCLES > SETTLE_CYCLES) ? SER_RST_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    lane_state_t   state_r;
    logic [TW-1:0] timer_r;
    logic          lock_s;
    logic          lock_stable_s;
    logic          test_sel_s;

`ifdef HDMI_OSER_TEST_PATTERN_EN
    assign test_sel_s = test_mode;
`else
    assign test_sel_s = 1'b0;
`endif

    hdmi_oser_lane_ctrl_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk         (paralell_clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .lock_s      (lock_s),
        .lock_stable (lock_stable_s)
    );

    // Word sent on a data lane while the link is running.
    function automatic logic [9:0] run_word(input logic tm, input logic v, input logic [9:0] w);
        logic [9:0] r;
        if (tm) begin
            r = CLK_WORD;
        end else if (v) begin
            r = w;
        end else begin
            r = IDLE_WORD;
        end
        return r;
    endfunction

    // Link FSM with all outputs registered; defaults describe the link-down
    // condition and each state overrides what it drives differently.
    always_ff @(posedge paralell_clk) begin
        if (reset) begin
            state_r           <= WAIT_LOCK;
            timer_r           <= '0;
            ser_reset         <= 1'b1;
            link_ready        <= 1'b0;
            lock_loss_cnt     <= '0;
            paralell_data_0   <= IDLE_WORD;
            paralell_data_1   <= IDLE_WORD;
            paralell_data_2   <= IDLE_WORD;
            paralell_data_clk <= CLK_WORD;
        end else begin
            ser_reset         <= 1'b1;
            link_ready        <= 1'b0;
            paralell_data_0   <= IDLE_WORD;
            paralell_data_1   <= IDLE_WORD;
            paralell_data_2   <= IDLE_WORD;
            paralell_data_clk <= CLK_WORD;
            timer_r           <= '0;
            case (state_r)
                WAIT_LOCK: begin
                    if (lock_stable_s) begin
                        state_r <= RST_HOLD;
                    end else begin
                        state_r <= WAIT_LOCK;
                    end
                end
                RST_HOLD: begin
                    if (!lock_s) begin
                        state_r       <= WAIT_LOCK;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if (timer_r == TW'(SER_RST_CYCLES - 1)) begin
                        state_r   <= SETTLE;
                        ser_reset <= 1'b0;
                    end else begin
                        state_r <= RST_HOLD;
                        timer_r <= timer_r + TW'(1);
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state_r       <= WAIT_LOCK;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if (timer_r == TW'(SETTLE_CYCLES - 1)) begin
                        state_r         <= RUN;
                        ser_reset       <= 1'b0;
                        link_ready      <= 1'b1;
                        paralell_data_0 <= run_word(test_sel_s, tmds_valid, tmds_in_0);
                        paralell_data_1 <= run_word(test_sel_s, tmds_valid, tmds_in_1);
                        paralell_data_2 <= run_word(test_sel_s, tmds_valid, tmds_in_2);
                    end else begin
                        state_r   <= SETTLE;
                        ser_reset <= 1'b0;
                        timer_r   <= timer_r + TW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_r       <= WAIT_LOCK;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else begin
                        state_r         <= RUN;
                        ser_reset       <= 1'b0;
                        link_ready      <= 1'b1;
                        paralell_data_0 <= run_word(test_sel_s, tmds_valid, tmds_in_0);
                        paralell_data_1 <= run_word(test_sel_s, tmds_valid, tmds_in_1);
                        paralell_data_2 <= run_word(test_sel_s, tmds_valid, tmds_in_2);
                    end
                end
                default: begin
                    state_r <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule
